// File: rtl/icache_direct_if.sv
// -----------------------------------------------------------------------------
// icache_direct_if
//   Groups the fetcher-side and memory-controller-side signals of the
//   direct-mapped instruction cache into one bundle.
//
//   master : environment view (instruction fetcher + memory controller)
//   slave  : cache view
//
//   clear          fetcher -> cache   pipeline flush, aborts outstanding fetch
//   fetch_req      fetcher -> cache   request, held until inst_ready
//   fetch_pc       fetcher -> cache   fetch address, bits [1:0] ignored
//   inst_ready     cache -> fetcher   one-cycle pulse, inst_out valid
//   inst_out       cache -> fetcher   instruction word
//   mem_if_enable  cache -> memctrl   word fetch request, held until mem_if_ready
//   mem_inst_addr  cache -> memctrl   word-aligned fetch address
//   mem_if_ready   memctrl -> cache   mem_inst valid this cycle
//   mem_inst       memctrl -> cache   fetched word
// -----------------------------------------------------------------------------
interface icache_direct_if;
   logic        clear;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic        mem_if_enable;
   logic [31:0] mem_inst_addr;
   logic        mem_if_ready;
   logic [31:0] mem_inst;

   modport master (
      output clear, fetch_req, fetch_pc, mem_if_ready, mem_inst,
      input  inst_ready, inst_out, mem_if_enable, mem_inst_addr
   );

   modport slave (
      input  clear, fetch_req, fetch_pc, mem_if_ready, mem_inst,
      output inst_ready, inst_out, mem_if_enable, mem_inst_addr
   );
endinterface

// File: rtl/icache_direct.sv
// -----------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, one-word-per-line, read-only instruction cache sitting
//   between the instruction fetcher and the memory controller's instruction
//   port. Hits return in one cycle; a miss issues a single word fetch, fills
//   the line and forwards the word.
//
// Ports
//   clk_in      system clock
//   rst_in      synchronous active-high reset
//   rdy_in      global ready; all state frozen while low
//   bus         icache_direct_if.slave (fetch + memory handshakes)
//   hit_count   (ICACHE_STAT_EN only) accepted-hit counter
//   miss_count  (ICACHE_STAT_EN only) accepted-miss counter
//
// Parameters
//   INDEX_WIDTH  log2 of line count
//   ADDR_WIDTH   significant PC bits;
//                tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2], index = pc[INDEX_WIDTH+1:2]
//
// Optional feature macro: ICACHE_STAT_EN (hit/miss statistics counters)
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | no fill outstanding; lookup on each accepted request
// MISS  | word fetch outstanding at latched index/tag, waiting mem_if_ready
// -----------------------------------------------------------------------------
module icache_direct #(
   parameter int INDEX_WIDTH = 6,
   parameter int ADDR_WIDTH  = 18
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   icache_direct_if.slave   bus
`ifdef ICACHE_STAT_EN
   ,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count
`endif
);

   localparam int LINES = 1 << INDEX_WIDTH;
   localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MISS = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;

   logic [LINES-1:0]       r_valid;
   logic [TAG_W-1:0]       r_tag  [LINES];
   logic [31:0]            r_data [LINES];

   logic                   r_inst_ready;
   logic [31:0]            r_inst_out;
   logic                   r_mem_if_enable;
   logic [31:0]            r_mem_inst_addr;
   logic [INDEX_WIDTH-1:0] r_miss_idx;
   logic [TAG_W-1:0]       r_miss_tag;

   logic                   w_inst_ready_next;
   logic [31:0]            w_inst_out_next;
   logic                   w_mem_en_next;
   logic [31:0]            w_mem_addr_next;
   logic [INDEX_WIDTH-1:0] w_miss_idx_next;
   logic [TAG_W-1:0]       w_miss_tag_next;
   logic                   w_fill;
   logic                   w_acc_hit;
   logic                   w_acc_miss;

   logic [INDEX_WIDTH-1:0] w_idx;
   logic [TAG_W-1:0]       w_tag;
   logic                   w_hit;
   logic                   w_unused_pc_lsb;

   assign w_idx = bus.fetch_pc[INDEX_WIDTH+1:2];
   assign w_tag = bus.fetch_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

   // Byte offset within the word never matters for an instruction fetch.
   assign w_unused_pc_lsb = ^bus.fetch_pc[1:0];

   assign bus.inst_ready    = r_inst_ready;
   assign bus.inst_out      = r_inst_out;
   assign bus.mem_if_enable = r_mem_if_enable;
   assign bus.mem_inst_addr = r_mem_inst_addr;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
      end else if (rdy_in) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_inst_ready_next = 1'b0;
      w_inst_out_next   = r_inst_out;
      w_mem_en_next     = r_mem_if_enable;
      w_mem_addr_next   = r_mem_inst_addr;
      w_miss_idx_next   = r_miss_idx;
      w_miss_tag_next   = r_miss_tag;
      w_fill            = 1'b0;
      w_acc_hit         = 1'b0;
      w_acc_miss        = 1'b0;

      // The memory controller sees the same clear and drops its transaction,
      // so a word arriving in a clear cycle is discarded rather than filled.
      if (bus.clear) begin
         w_state_next  = S_IDLE;
         w_mem_en_next = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // inst_ready high means the fetcher is only now moving to its
               // next pc; the current fetch_pc is stale for one cycle.
               if (bus.fetch_req && !r_inst_ready) begin
                  if (w_hit) begin
                     w_inst_ready_next = 1'b1;
                     w_inst_out_next   = r_data[w_idx];
                     w_acc_hit         = 1'b1;
                  end else begin
                     w_mem_en_next   = 1'b1;
                     w_mem_addr_next = {bus.fetch_pc[31:2], 2'b00};
                     w_miss_idx_next = w_idx;
                     w_miss_tag_next = w_tag;
                     w_acc_miss      = 1'b1;
                     w_state_next    = S_MISS;
                  end
               end
            end
            S_MISS: begin
               if (bus.mem_if_ready) begin
                  w_fill            = 1'b1;
                  w_inst_ready_next = 1'b1;
                  w_inst_out_next   = bus.mem_inst;
                  w_mem_en_next     = 1'b0;
                  w_state_next      = S_IDLE;
               end
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_inst_ready    <= 1'b0;
         r_inst_out      <= '0;
         r_mem_if_enable <= 1'b0;
         r_mem_inst_addr <= '0;
         r_miss_idx      <= '0;
         r_miss_tag      <= '0;
         r_valid         <= '0;
      end else if (rdy_in) begin
         r_inst_ready    <= w_inst_ready_next;
         r_inst_out      <= w_inst_out_next;
         r_mem_if_enable <= w_mem_en_next;
         r_mem_inst_addr <= w_mem_addr_next;
         r_miss_idx      <= w_miss_idx_next;
         r_miss_tag      <= w_miss_tag_next;
         if (w_fill) begin
            r_valid[r_miss_idx] <= 1'b1;
         end
      end
   end

   // Tag/data arrays carry no reset; valid bits alone decide hits.
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && w_fill) begin
         r_tag[r_miss_idx]  <= r_miss_tag;
         r_data[r_miss_idx] <= bus.mem_inst;
      end
   end

`ifdef ICACHE_STAT_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if (rdy_in) begin
         if (w_acc_hit) begin
            r_hit_count <= r_hit_count + 32'd1;
         end
         if (w_acc_miss) begin
            r_miss_count <= r_miss_count + 32'd1;
         end
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`else
   logic w_unused_stat;
   assign w_unused_stat = w_acc_hit ^ w_acc_miss;
`endif

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction fetcher (upstream) and the memory controller's instruction port (downstream).
- Hits are served in 1 cycle with no memory traffic.
- On a miss, the block issues a single word fetch to the memory controller, waits for it, fills the line and forwards the word.
- It is read-only: no self-modifying-code support and no invalidate port.

Parameters:
- INDEX_WIDTH, 6, log2 of line count (64 lines).
- ADDR_WIDTH, 18, significant PC bits. Tag = pc[ADDR_WIDTH-1 : INDEX_WIDTH+2], index = pc[INDEX_WIDTH+1 : 2].

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; all state frozen when low
- clear  input  1  pipeline flush (branch mispredict); aborts any outstanding fetch
- fetch_req  input  1  fetcher requests the instruction at fetch_pc; held until inst_ready
- fetch_pc  input  32  fetch address; bits [1:0] ignored
- inst_ready  output  1  one-cycle pulse: inst_out valid for the pending request
- inst_out  output  32  fetched instruction word
- mem_if_enable  output  1  to memory controller: word fetch request, held until mem_if_ready
- mem_inst_addr  output  32  to memory controller: word-aligned fetch address
- mem_if_ready  input  1  from memory controller: mem_inst valid this cycle
- mem_inst  input  32  from memory controller: fetched word

Behaviour:
- Reset (rst_in=1 at posedge):
  - All valid bits cleared; state IDLE.
  - inst_ready=0, inst_out=0, mem_if_enable=0, mem_inst_addr=0.
  - Reset mid-miss abandons the fill.
- rdy_in=0: no register, array or state update; outputs hold. Reset still takes priority.
- Storage: valid[2^INDEX_WIDTH], tag[2^INDEX_WIDTH], data[2^INDEX_WIDTH] x 32.
- inst_ready is a registered pulse and defaults to 0 every cycle unless set below.
- State IDLE:
  - A request is accepted when fetch_req=1, inst_ready=0 and clear=0. Because the fetcher updates fetch_pc on the ready edge, hit throughput is 1 per 2 cycles.
  - Hit (valid[idx] and tag match): next edge sets inst_ready=1 and inst_out=data[idx]. Latency is 1 cycle and no memory access occurs.
  - Miss: next edge sets mem_inst_addr={fetch_pc[31:2],2'b00}, mem_if_enable=1, latches idx/tag, and moves to MISS.
- State MISS:
  - mem_if_enable and mem_inst_addr are held stable.
  - On mem_if_ready=1 and clear=0: write data/tag and set valid at the latched idx; inst_out=mem_inst, inst_ready=1, mem_if_enable=0; go to IDLE.
  - Miss latency = memctrl latency + 1 cycle.
- clear (any state, priority over all except reset):
  - Next state IDLE; mem_if_enable=0, inst_ready=0.
  - No array write, even if mem_if_ready is high the same cycle.
  - Valid bits are preserved.
  - fetch_req in a clear cycle is ignored.
  - The memory controller receives the same clear and drops its transaction.
- Replacement: a conflicting index overwrites unconditionally.
- fetch_pc changing while in MISS is a protocol violation. The cache completes the latched address.

Optional Feature:
- ICACHE_STAT_EN defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Reset to 0.
  - Each increments by 1 per accepted hit or miss; wraps at 2^32.
  - Frozen when rdy_in=0.
  - Not cleared by clear.
- Undefined: ports and counters are absent. Functional behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch_req with pc 0x00000000; memctrl returns 0x00000013 with mem_if_ready 5 cycles after mem_if_enable.
  - Response: mem_if_enable rises 1 cycle after request with addr 0x0; inst_ready pulses exactly 1 cycle after mem_if_ready with inst_out=0x00000013.
- Hit:
  - Stimulus: refetch 0x00000000.
  - Response: inst_ready the next cycle with 0x00000013; mem_if_enable stays 0.
- Conflict:
  - Stimulus: with INDEX_WIDTH=6, fetch 0x00000100 (idx 0, new tag), memctrl returns 0x00100093; then fetch 0x00000000.
  - Response: both fetches miss; the second returns 0x00000013 via memory.
- Clear mid-miss:
  - Stimulus: pulse clear 2 cycles into a miss on 0x00000008 (0x00000013 on the memory bus); then fetch 0x00000008 again.
  - Response: mem_if_enable drops next cycle; no inst_ready; the refetch misses.
- Clear and mem_if_ready coincide:
  - Stimulus: clear and mem_if_ready in the same cycle.
  - Response: no inst_ready, line not filled.
- Freeze and reset:
  - Stimulus: rdy_in=0 for 3 cycles on a hit accept.
  - Response: inst_ready is delayed exactly 3 cycles.
  - Stimulus: rst_in after fills.
  - Response: all prior addresses miss. With ICACHE_STAT_EN, counters read 0 after reset and 1 hit / 1 miss after a miss then hit.
